// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving a core and a loader port shared access to one single-port memory.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e state_q;
  logic ptr_q, sel_q, we_q, c_ack_q, l_ack_q, mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, c_rdata_q, l_rdata_q;
  logic sel_d;
  // ptr_q=1 favours the loader; a lone requester wins regardless
  assign sel_d = l_req & (~c_req | ptr_q);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      c_ack_q     <= 1'b0;
      l_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      c_ack_q <= 1'b0;
      l_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (c_req | l_req) begin
          sel_q       <= sel_d;
          ptr_q       <= ~sel_d;
          we_q        <= sel_d ? l_we : c_we;
          mem_en_q    <= 1'b1;
          mem_we_q    <= sel_d ? l_we : c_we;
          mem_addr_q  <= sel_d ? l_addr : c_addr;
          mem_wdata_q <= sel_d ? l_wdata : c_wdata;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          c_ack_q  <= ~sel_q;
          l_ack_q  <= sel_q;
          state_q  <= RESP;
        end
        RESP: begin
          // read data arrives during RESP and lands in the winner's register at its end
          if (!we_q && sel_q) l_rdata_q <= mem_rdata;
          if (!we_q && !sel_q) c_rdata_q <= mem_rdata;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign c_ack     = c_ack_q;
  assign l_ack     = l_ack_q;
  assign c_rdata   = c_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized transaction-level scoreboard.
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic c_req = 0, c_we = 0, l_req = 0, l_we = 0;
  logic [7:0] c_addr = 0, c_wdata = 0, l_addr = 0, l_wdata = 0;
  logic [7:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
  logic c_ack, l_ack, mem_en, mem_we, busy;
  logic ini_we = 0;
  logic [7:0] ini_a = 0, ini_d = 0;
  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:255];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_rdata(l_rdata), .l_ack(l_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (ini_we) mem[ini_a] <= ini_d;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic creq, cwe; logic [7:0] caddr, cwd;
    logic lreq, lwe; logic [7:0] laddr, lwd;
    logic e_cack, e_lack, e_busy, e_men, e_mwe; logic [7:0] e_crd, e_lrd;
  } vec_t;
  vec_t vt [9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ini_we = 1; ini_a = a; ini_d = d; ref_mem[a] = d;
    tick();
    ini_we = 0;
  endtask

  task automatic rst_pulse();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic idle_chk(input string nm);
    chk1({nm, "_men"}, mem_en, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_cack"}, c_ack, 1'b0);
    chk1({nm, "_lack"}, l_ack, 1'b0);
  endtask

  // Scoreboard state: one transaction in flight at most, next grant three edges after the last
  int next_ok, t_edge;
  bit pref_l, t_act, t_l, t_we, pend_c, pend_l, w_l;
  logic [7:0] t_addr, t_wd, t_rd, exp_crd, exp_lrd;

  initial begin
    vt[0] = '{1'b1,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0, 8'h00,8'h00};
    vt[1] = '{1'b1,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0, 8'h00,8'h00};
    vt[2] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0, 8'hF0,8'h00};
    vt[3] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h02,8'hF1, 1'b0,1'b0,1'b1,1'b1,1'b1, 8'hF0,8'h00};
    vt[4] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h02,8'hF1, 1'b0,1'b1,1'b1,1'b0,1'b0, 8'hF0,8'h00};
    vt[5] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0, 8'hF0,8'h00};
    vt[6] = '{1'b1,1'b0,8'h02,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0, 8'hF0,8'h00};
    vt[7] = '{1'b1,1'b0,8'h02,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0, 8'hF0,8'h00};
    vt[8] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0, 8'hF1,8'h00};

    // asynchronous reset takes effect before any clock edge
    #2 reset = 0;
    #1;
    idle_chk("rst");
    chk1("rst_mwe", mem_we, 1'b0);
    chk8("rst_crd", c_rdata, 8'h00);
    chk8("rst_lrd", l_rdata, 8'h00);
    chk8("rst_maddr", mem_addr, 8'h00);
    chk8("rst_mwd", mem_wdata, 8'h00);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h00, 8'hF0);
    poke(8'h02, 8'h00);
    poke(8'h03, 8'hC3);
    poke(8'h04, 8'h55);
    reset = 1;

    // core read, loader write, core read back
    for (int i = 0; i < 9; i++) begin
      c_req = vt[i].creq; c_we = vt[i].cwe; c_addr = vt[i].caddr; c_wdata = vt[i].cwd;
      l_req = vt[i].lreq; l_we = vt[i].lwe; l_addr = vt[i].laddr; l_wdata = vt[i].lwd;
      tick();
      chk1($sformatf("v%0d_cack", i), c_ack, vt[i].e_cack);
      chk1($sformatf("v%0d_lack", i), l_ack, vt[i].e_lack);
      chk1($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk1($sformatf("v%0d_men", i), mem_en, vt[i].e_men);
      chk1($sformatf("v%0d_mwe", i), mem_we, vt[i].e_mwe);
      chk8($sformatf("v%0d_crd", i), c_rdata, vt[i].e_crd);
      chk8($sformatf("v%0d_lrd", i), l_rdata, vt[i].e_lrd);
    end

    // both held after reset: core, loader, core, loader at three-cycle spacing
    c_req = 1; c_we = 0; c_addr = 8'h00;
    l_req = 1; l_we = 0; l_addr = 8'h03;
    rst_pulse();
    for (int i = 0; i < 11; i++) begin
      tick();
      chk1($sformatf("rr%0d_cack", i), c_ack, i % 6 == 1);
      chk1($sformatf("rr%0d_lack", i), l_ack, i % 6 == 4);
      chk1($sformatf("rr%0d_excl", i), c_ack & l_ack, 1'b0);
    end
    chk8("rr_crd", c_rdata, 8'hF0);
    chk8("rr_lrd", l_rdata, 8'hC3);
    c_req = 0; l_req = 0;
    tick();
    tick();

    for (int i = 0; i < 10; i++) begin
      tick();
      idle_chk($sformatf("idle%0d", i));
    end

    // reset during the RESP cycle of a core read, then reissue
    c_req = 1; c_addr = 8'h00;
    tick();
    tick();
    chk1("ab_resp_cack", c_ack, 1'b1);
    #2 reset = 0;
    #1;
    chk1("ab_cack", c_ack, 1'b0);
    chk1("ab_busy", busy, 1'b0);
    chk8("ab_crd", c_rdata, 8'h00);
    tick();
    tick();
    idle_chk("ab_hold");
    reset = 1;
    tick();
    chk1("ab_regrant", mem_en, 1'b1);
    tick();
    chk1("ab_recack", c_ack, 1'b1);
    c_req = 0;
    tick();
    chk8("ab_recrd", c_rdata, 8'hF0);

    // loader-only back-to-back reads
    l_req = 1; l_we = 0; l_addr = 8'h03;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1($sformatf("lb%0d_lack", i), l_ack, i == 1 || i == 4);
      if (i == 1) l_addr = 8'h04;
      if (i == 2) chk8("lb_first", l_rdata, 8'hC3);
      if (i == 4) l_req = 0;
    end
    chk8("lb_second", l_rdata, 8'h55);
    chk8("lb_crd", c_rdata, 8'hF0);

    // randomized traffic against the scoreboard
    c_req = 0; l_req = 0;
    rst_pulse();
    next_ok = 0; pref_l = 0; t_act = 0; t_edge = 0; pend_c = 0; pend_l = 0;
    exp_crd = 0; exp_lrd = 0;
    for (int e = 0; e < 1500; e++) begin
      if (!pend_c) begin
        pend_c = $urandom_range(0, 2) == 0;
        c_req = pend_c; c_we = 1'($urandom);
        c_addr = 8'(8 + $urandom_range(0, 7)); c_wdata = 8'($urandom);
      end
      if (!pend_l) begin
        pend_l = $urandom_range(0, 2) == 0;
        l_req = pend_l; l_we = 1'($urandom);
        l_addr = 8'(8 + $urandom_range(0, 7)); l_wdata = 8'($urandom);
      end
      if (e >= next_ok && (c_req || l_req)) begin
        w_l = l_req && (!c_req || pref_l);
        pref_l = !w_l;
        t_act = 1; t_edge = e; t_l = w_l; next_ok = e + 3;
        t_we = w_l ? l_we : c_we;
        t_addr = w_l ? l_addr : c_addr;
        t_wd = w_l ? l_wdata : c_wdata;
        if (t_we) ref_mem[t_addr] = t_wd;
        else t_rd = ref_mem[t_addr];
      end
      tick();
      if (t_act && e == t_edge + 2 && !t_we) begin
        if (t_l) exp_lrd = t_rd;
        else exp_crd = t_rd;
      end
      chk1("rnd_cack", c_ack, t_act && e == t_edge + 1 && !t_l);
      chk1("rnd_lack", l_ack, t_act && e == t_edge + 1 && t_l);
      chk1("rnd_busy", busy, t_act && (e == t_edge || e == t_edge + 1));
      chk1("rnd_men", mem_en, t_act && e == t_edge);
      chk8("rnd_crd", c_rdata, exp_crd);
      chk8("rnd_lrd", l_rdata, exp_lrd);
      if (t_act && e == t_edge) begin
        chk1("rnd_mwe", mem_we, t_we);
        chk8("rnd_maddr", mem_addr, t_addr);
        chk8("rnd_mwd", mem_wdata, t_wd);
      end
      if (c_ack) pend_c = 0;
      if (l_ack) pend_l = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, data memory address width.
REQ-002 SHALL have parameter DW, default 8, data memory word width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have ports c_req/c_we  input  1/1  core request and write-enable.
REQ-006 SHALL have ports c_addr/c_wdata  input  AW/DW  core address and write data.
REQ-007 SHALL have ports c_rdata/c_ack  output  DW/1  core read data and completion pulse.
REQ-008 SHALL have ports l_req/l_we  input  1/1  loader (test/DMA) request and write-enable.
REQ-009 SHALL have ports l_addr/l_wdata  input  AW/DW  loader address and write data.
REQ-010 SHALL have ports l_rdata/l_ack  output  DW/1  loader read data and completion pulse.
REQ-011 SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  output  1/1/AW/DW  single-port data memory drive.
REQ-012 SHALL have port mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 IDLE: if any req high at edge, SHALL latch winner, its we/addr/wdata, go ACCESS; else stay IDLE.
REQ-016 ACCESS: SHALL drive mem_en=1, mem_we/addr/wdata from latched winner for exactly one cycle, then go RESP.
REQ-017 RESP: SHALL pulse winner's ack for exactly one cycle; on read, capture mem_rdata into winner's rdata register; then go IDLE.
REQ-018 Latency SHALL be: req seen at edge n, mem access cycle n+1, ack high cycle n+2; next grant no earlier than edge n+3.
REQ-019 Arbitration SHALL be round-robin: on simultaneous req, the port not granted last wins; priority pointer updates only on grant.
REQ-020 After reset the priority pointer SHALL favour the core.
REQ-021 Single requester SHALL always be granted regardless of pointer.
REQ-022 Requesters SHALL hold req and operands stable until ack; arbiter SHALL ignore req changes outside IDLE.
REQ-023 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-024 c_rdata/l_rdata SHALL hold their last captured value until the next read completing on that port; writes SHALL not alter them.
REQ-025 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold latched values.
REQ-026 c_ack and l_ack SHALL never be high in the same cycle.
REQ-027 Non-winning requester SHALL see no ack and SHALL be served in the next arbitration.

Reset
REQ-028 On reset=0, asynchronously: state=IDLE, pointer=core, c_ack=l_ack=0, mem_en=mem_we=0, busy=0, c_rdata=l_rdata=0, mem_addr=mem_wdata=0.
REQ-029 Reset asserted in ACCESS or RESP SHALL abort the transaction: no ack issued, no further mem_en; memory write already in ACCESS cycle may complete.
REQ-030 After reset release, first grant SHALL occur at the first rising edge with reset=1 and a req high.

Verification
REQ-031 Core read: mem[0]=8'hF0, c_req=1, c_we=0, c_addr=0 -> mem_en one cycle later, c_ack two cycles later, c_rdata=8'hF0.
REQ-032 Loader write then core read: l_we=1, l_addr=2, l_wdata=8'hF1; then core reads addr 2 -> c_rdata=8'hF1, l_rdata unchanged (0).
REQ-033 Simultaneous req after reset, both held -> core acked first, loader acked 3 cycles later, then core again; acks never overlap.
REQ-034 Loader-only back-to-back reads of addrs 3,4 (8'hC3, 8'h55) -> l_ack every 3 cycles, l_rdata 8'hC3 then 8'h55, pointer irrelevant.
REQ-035 Reset pulled low during RESP of a core read -> no c_ack, busy=0 and c_rdata=0 immediately; after release, re-issued read completes normally.
REQ-036 Idle with no req for 10 cycles -> mem_en=0, busy=0, both acks 0 throughout.
